debug_arbiter: RTL and testbench

DEBUG_ARBITER -- requirements
Module: debug_arbiter

---
 rtl/debug_arbiter_pkg.sv | 8 +
 rtl/debug_arbiter_if.sv | 20 ++
 rtl/debug_arbiter_rr_arb2.sv | 11 +
 rtl/debug_arbiter.sv | 62 ++++++
 tb/tb_debug_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_arbiter_pkg.sv
// debug_arbiter_pkg: shared sizes, requester ids and FSM encoding for the debug arbiter
package debug_arbiter_pkg;
  localparam int DEF_LOG_CORES = 3;
  localparam int DEF_DATA_WIDTH = 16;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
endpackage

// File: rtl/debug_arbiter_if.sv
// debug_arbiter_if: both requester ports plus the shared debugger bus
interface debug_arbiter_if import debug_arbiter_pkg::*; #(
  parameter int LOG_CORES = DEF_LOG_CORES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic wb_req, wb_we, wb_ack, la_req, la_we, la_ack, debug_we;
  logic [LOG_CORES-1:0] wb_sel, la_sel, debug_sel;
  logic [4:0] wb_addr, la_addr, debug_addr;
  logic [DATA_WIDTH-1:0] wb_wdata, la_wdata, wb_rdata, la_rdata, debug_wdata, debug_rdata;
  modport master (
    output wb_req, wb_we, wb_sel, wb_addr, wb_wdata,
    output la_req, la_we, la_sel, la_addr, la_wdata, debug_rdata,
    input wb_ack, wb_rdata, la_ack, la_rdata, debug_sel, debug_addr, debug_we, debug_wdata
  );
  modport slave (
    input wb_req, wb_we, wb_sel, wb_addr, wb_wdata,
    input la_req, la_we, la_sel, la_addr, la_wdata, debug_rdata,
    output wb_ack, wb_rdata, la_ack, la_rdata, debug_sel, debug_addr, debug_we, debug_wdata
  );
endinterface

// File: rtl/debug_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not granted last wins
module rr_arb2 import debug_arbiter_pkg::*; (
  input logic req_a,
  input logic req_b,
  input logic last,
  output logic id,
  output logic valid
);
  assign valid = req_a | req_b;
  assign id = (req_a & req_b) ? ~last : (req_b ? ID_B : ID_A);
endmodule

// File: rtl/debug_arbiter.sv
// debug_arbiter: shares one debugger bus between the wishbone and logic-analyzer requesters
module debug_arbiter import debug_arbiter_pkg::*; #(
  parameter int LOG_CORES = DEF_LOG_CORES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic wb_clk_i,
  input logic wb_rst_n,
  debug_arbiter_if.slave bus
);
  state_t state;
  logic last, id, win, win_valid, we_w;
  logic [LOG_CORES-1:0] sel_w;
  logic [4:0] addr_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  rr_arb2 u_rr (.req_a(bus.wb_req), .req_b(bus.la_req), .last(last), .id(win), .valid(win_valid));
  assign we_w = win ? bus.la_we : bus.wb_we;
  assign sel_w = win ? bus.la_sel : bus.wb_sel;
  assign addr_w = win ? bus.la_addr : bus.wb_addr;
  assign wdata_w = win ? bus.la_wdata : bus.wb_wdata;
  // debug_* registers double as the latched request fields; they hold data only during GRANT
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last <= ID_B;
      id <= ID_A;
      bus.debug_sel <= '0;
      bus.debug_addr <= '0;
      bus.debug_we <= 1'b0;
      bus.debug_wdata <= '0;
      bus.wb_ack <= 1'b0;
      bus.la_ack <= 1'b0;
      bus.wb_rdata <= '0;
      bus.la_rdata <= '0;
    end else begin
      bus.debug_sel <= '0;
      bus.debug_addr <= '0;
      bus.debug_we <= 1'b0;
      bus.debug_wdata <= '0;
      bus.wb_ack <= 1'b0;
      bus.la_ack <= 1'b0;
      case (state)
        IDLE: if (win_valid) begin
          state <= GRANT;
          last <= win;
          id <= win;
          bus.debug_sel <= sel_w;
          bus.debug_addr <= addr_w;
          bus.debug_we <= we_w;
          bus.debug_wdata <= wdata_w;
        end
        GRANT: begin
          state <= RESP;
          bus.wb_ack <= id == ID_A;
          bus.la_ack <= id == ID_B;
          if (!bus.debug_we && id == ID_A) bus.wb_rdata <= bus.debug_rdata;
          if (!bus.debug_we && id == ID_B) bus.la_rdata <= bus.debug_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_arbiter.sv
// tb_debug_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// transaction-level model of the two requesters sharing the debugger bus
module tb_debug_arbiter;
  import debug_arbiter_pkg::*;
  localparam int LC = DEF_LOG_CORES;
  localparam int DW = DEF_DATA_WIDTH;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  debug_arbiter_if #(.LOG_CORES(LC), .DATA_WIDTH(DW)) bus ();
  debug_arbiter #(.LOG_CORES(LC), .DATA_WIDTH(DW)) dut (.wb_clk_i(clk), .wb_rst_n(rst_n), .bus(bus));
  logic [DW-1:0] env_mem [8][32];
  logic bd_en = 1'b0;
  logic [2:0] bd_s = '0;
  logic [4:0] bd_a = '0;
  logic [DW-1:0] bd_d = '0;
  always @(posedge clk)
    if (bd_en) env_mem[bd_s][bd_a] <= bd_d;
    else if (bus.debug_we) env_mem[bus.debug_sel][bus.debug_addr] <= bus.debug_wdata;
  assign bus.debug_rdata = env_mem[bus.debug_sel][bus.debug_addr];
  logic r_req [2];
  logic r_we [2];
  logic [2:0] r_sel [2];
  logic [4:0] r_addr [2];
  logic [DW-1:0] r_wd [2];
  assign bus.wb_req = r_req[0];
  assign bus.wb_we = r_we[0];
  assign bus.wb_sel = r_sel[0];
  assign bus.wb_addr = r_addr[0];
  assign bus.wb_wdata = r_wd[0];
  assign bus.la_req = r_req[1];
  assign bus.la_we = r_we[1];
  assign bus.la_sel = r_sel[1];
  assign bus.la_addr = r_addr[1];
  assign bus.la_wdata = r_wd[1];
  logic [24:0] dbg;
  logic [1:0] acks;
  logic [31:0] rds;
  assign dbg = {bus.debug_sel, bus.debug_addr, bus.debug_we, bus.debug_wdata};
  assign acks = {bus.wb_ack, bus.la_ack};
  assign rds = {bus.wb_rdata, bus.la_rdata};
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_req(input int r, input logic q, input logic w, input logic [2:0] s,
                         input logic [4:0] a, input logic [DW-1:0] d);
    r_req[r] = q;
    r_we[r] = w;
    r_sel[r] = s;
    r_addr[r] = a;
    r_wd[r] = d;
  endtask
  task automatic clear_reqs();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
  endtask
  task automatic new_txn(input int r);
    set_req(r, 1'b1, 1'($urandom_range(1)), 3'($urandom), 5'($urandom), 16'($urandom));
  endtask
  task automatic bd_write(input logic [2:0] s, input logic [4:0] a, input logic [DW-1:0] d);
    bd_en = 1'b1;
    bd_s = s;
    bd_a = a;
    bd_d = d;
    step();
    bd_en = 1'b0;
  endtask
  task automatic do_rst();
    rst_n = 1'b0;
    clear_reqs();
    step();
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic ra, rb, wa, wb_;
    logic [2:0] sa, sb;
    logic [4:0] aa, ab;
    logic [15:0] da, db, mv;
    logic [24:0] ebus;
    logic [1:0] eack;
    logic [31:0] erd;
  } vec_t;
  vec_t vt [6];
  logic [DW-1:0] ref_mem [8][32];
  logic [DW-1:0] mdl_rd [2];
  logic inflight [2];
  int last_won, next_free, g_edge, w;
  logic g_id, g_we;
  logic [24:0] g_bus;
  logic [DW-1:0] g_rd;
  initial begin
    vt[0] = '{1, 0, 0, 0, 2, 0, 5, 0, 16'hAAAA, 0, 16'h1234, {3'd2, 5'd5, 1'b0, 16'hAAAA}, 2'b10, 32'h1234_0000};
    vt[1] = '{0, 1, 0, 1, 0, 7, 0, 31, 0, 16'hBEEF, 16'h5555, {3'd7, 5'd31, 1'b1, 16'hBEEF}, 2'b01, 32'h0};
    vt[2] = '{1, 1, 0, 0, 1, 4, 3, 9, 0, 0, 16'h0F0F, {3'd1, 5'd3, 1'b0, 16'h0}, 2'b10, 32'h0F0F_0000};
    vt[3] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h2222, 16'hCAFE, {3'd0, 5'd0, 1'b0, 16'h2222}, 2'b01, 32'h0000_CAFE};
    vt[4] = '{1, 1, 1, 0, 3, 5, 7, 1, 16'h1111, 0, 16'h3333, {3'd3, 5'd7, 1'b1, 16'h1111}, 2'b10, 32'h0};
    vt[5] = '{1, 0, 0, 0, 7, 0, 31, 0, 0, 0, 16'hFFFF, {3'd7, 5'd31, 1'b0, 16'h0}, 2'b10, 32'hFFFF_0000};
    clear_reqs();
    foreach (vt[i]) begin
      rst_n = 1'b0;
      clear_reqs();
      bd_write(vt[i].sa, vt[i].aa, vt[i].mv);
      bd_write(vt[i].sb, vt[i].ab, vt[i].mv);
      chk("reset_state", {dbg, acks, rds}, 0);
      rst_n = 1'b1;
      set_req(0, vt[i].ra, vt[i].wa, vt[i].sa, vt[i].aa, vt[i].da);
      set_req(1, vt[i].rb, vt[i].wb_, vt[i].sb, vt[i].ab, vt[i].db);
      step();
      chk("vec_bus", dbg, vt[i].ebus);
      chk("vec_noack", acks, 0);
      step();
      chk("vec_ack", acks, vt[i].eack);
      chk("vec_rdata", rds, vt[i].erd);
      chk("vec_bus_off", dbg, 0);
      clear_reqs();
      step();
      chk("vec_idle", {dbg, acks}, 0);
    end
    do_rst();
    set_req(0, 1, 0, 1, 1, 0);
    set_req(1, 1, 0, 2, 2, 0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_ack", acks, (k == 1 || k == 7) ? 2'b10 : (k == 4 ? 2'b01 : 2'b00));
    end
    clear_reqs();
    step();
    do_rst();
    set_req(0, 1, 0, 2, 5, 0);
    step();
    chk("hold_addr", bus.debug_addr, 5);
    r_addr[0] = 9;
    step();
    chk("hold_ack", acks, 2'b10);
    chk("hold_bus_off", dbg, 0);
    clear_reqs();
    step();
    do_rst();
    set_req(0, 1, 1, 1, 2, 16'h7777);
    step();
    chk("rst_grant_bus", dbg, {3'd1, 5'd2, 1'b1, 16'h7777});
    rst_n = 1'b0;
    step();
    chk("rst_abort", {dbg, acks, rds}, 0);
    rst_n = 1'b1;
    clear_reqs();
    step();
    chk("rst_noack", acks, 0);
    set_req(0, 1, 0, 0, 0, 0);
    step();
    chk("rst_relat_bus", dbg, 0);
    chk("rst_relat_noack", acks, 0);
    step();
    chk("rst_relat_ack", acks, 2'b10);
    clear_reqs();
    step();
    do_rst();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_quiet", {dbg, acks}, 0);
    end
    rst_n = 1'b0;
    clear_reqs();
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 32; a++) begin
        ref_mem[s][a] = 16'($urandom);
        bd_write(3'(s), 5'(a), ref_mem[s][a]);
      end
    rst_n = 1'b1;
    mdl_rd[0] = '0;
    mdl_rd[1] = '0;
    inflight[0] = 1'b0;
    inflight[1] = 1'b0;
    last_won = 1;
    next_free = 0;
    g_edge = -10;
    g_id = 1'b0;
    g_we = 1'b0;
    g_bus = '0;
    g_rd = '0;
    for (int e = 0; e < 900; e++) begin
      if (e >= next_free && (r_req[0] || r_req[1])) begin
        w = (r_req[0] && r_req[1]) ? 1 - last_won : (r_req[1] ? 1 : 0);
        last_won = w;
        g_edge = e;
        g_id = w[0];
        inflight[w] = 1'b1;
        g_bus = {r_sel[w], r_addr[w], r_we[w], r_wd[w]};
        g_we = r_we[w];
        g_rd = ref_mem[r_sel[w]][r_addr[w]];
        if (r_we[w]) ref_mem[r_sel[w]][r_addr[w]] = r_wd[w];
        next_free = e + 3;
      end
      step();
      if (e == g_edge + 1 && !g_we) mdl_rd[g_id] = g_rd;
      chk("rnd_bus", dbg, e == g_edge ? g_bus : 25'd0);
      chk("rnd_ack", acks, e == g_edge + 1 ? (g_id ? 2'b01 : 2'b10) : 2'b00);
      chk("rnd_rdata", rds, {mdl_rd[0], mdl_rd[1]});
      for (int r = 0; r < 2; r++) begin
        if (e == g_edge + 1 && int'(g_id) == r) begin
          inflight[r] = 1'b0;
          if ($urandom_range(1) == 1) new_txn(r);
          else r_req[r] = 1'b0;
        end else if (inflight[r]) begin
          if ($urandom_range(3) == 0) begin
            new_txn(r);
          end
        end else if (!r_req[r]) begin
          if ($urandom_range(2) == 0) new_txn(r);
        end else if ($urandom_range(9) == 0) begin
          r_req[r] = 1'b0;
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
